// File: rtl/mc_controller.sv
// ============================================================================
// Module   : mc_controller
// Purpose  : Multicycle MIPS sequencer: fetch/decode/execute/memory/writeback
//            control with dmem wait-state timeout and exception pulse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mc_controller #(
  parameter int DMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        overflow,
  input  logic        dmem_ready,
  output logic        imem_en,
  output logic        ir_en,
  output logic        pc_en,
  output logic        memtoreg,
  output logic        pcsrc,
  output logic        alusrc,
  output logic        regdst,
  output logic        regwrite,
  output logic        jump,
  output logic [2:0]  alucontrol,
  output logic        dmem_en,
  output logic        dmem_we,
  output logic        exc,
  output logic        busy
);

  localparam int CW = $clog2(DMEM_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_FWAIT  = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_MEM    = 3'd5;
  localparam logic [2:0] S_WB     = 3'd6;

  localparam logic [2:0] C_RTYPE   = 3'd0;
  localparam logic [2:0] C_ADDI    = 3'd1;
  localparam logic [2:0] C_LW      = 3'd2;
  localparam logic [2:0] C_SW      = 3'd3;
  localparam logic [2:0] C_BEQ     = 3'd4;
  localparam logic [2:0] C_J       = 3'd5;
  localparam logic [2:0] C_ILLEGAL = 3'd6;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [2:0]    r_state;
  logic [2:0]    r_class;
  logic [CW-1:0] r_wait;
  logic [2:0]    w_next;
  logic [2:0]    w_class;
  logic          w_funct_ok;
  logic [2:0]    w_alu_funct;
  logic [2:0]    w_alu_exec;
  logic          w_ovf_op;
  logic          w_timeout;
  logic          w_unused_instr;

  wire [5:0] w_op    = instr[31:26];
  wire [5:0] w_funct = instr[5:0];

  assign w_unused_instr = ^instr[25:6];

  always_comb begin
    w_funct_ok  = 1'b1;
    w_alu_funct = ALU_ADD;
    case (w_funct)
      6'b100000: w_alu_funct = ALU_ADD;
      6'b100010: w_alu_funct = ALU_SUB;
      6'b100100: w_alu_funct = ALU_AND;
      6'b100101: w_alu_funct = ALU_OR;
      6'b101010: w_alu_funct = ALU_SLT;
      default:   w_funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    case (w_op)
      6'b000000: w_class = w_funct_ok ? C_RTYPE : C_ILLEGAL;
      6'b001000: w_class = C_ADDI;
      6'b100011: w_class = C_LW;
      6'b101011: w_class = C_SW;
      6'b000100: w_class = C_BEQ;
      6'b000010: w_class = C_J;
      default:   w_class = C_ILLEGAL;
    endcase
  end

  always_comb begin
    case (r_class)
      C_RTYPE:             w_alu_exec = w_alu_funct;
      C_ADDI, C_LW, C_SW:  w_alu_exec = ALU_ADD;
      C_BEQ:               w_alu_exec = ALU_SUB;
      default:             w_alu_exec = 3'b000;
    endcase
  end

  // slt can overflow internally but never traps; only add/sub/addi do
  assign w_ovf_op  = (r_class == C_ADDI) ||
                     ((r_class == C_RTYPE) && ((w_funct == 6'b100000) || (w_funct == 6'b100010)));
  assign w_timeout = (r_wait == CW'(DMEM_TIMEOUT - 1)) && !dmem_ready;

  always_comb begin
    w_next     = r_state;
    imem_en    = 1'b0;
    ir_en      = 1'b0;
    pc_en      = 1'b0;
    memtoreg   = 1'b0;
    pcsrc      = 1'b0;
    alusrc     = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    jump       = 1'b0;
    alucontrol = 3'b000;
    dmem_en    = 1'b0;
    dmem_we    = 1'b0;
    exc        = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (run) w_next = S_FETCH;
      end
      S_FETCH: begin
        imem_en = 1'b1;
        w_next  = S_FWAIT;
      end
      S_FWAIT: begin
        ir_en  = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_class == C_ILLEGAL) begin
          exc    = 1'b1;
          pc_en  = 1'b1;
          w_next = S_IDLE;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        alusrc     = (r_class == C_ADDI) || (r_class == C_LW) || (r_class == C_SW);
        alucontrol = w_alu_exec;
        case (r_class)
          C_BEQ: begin
            pc_en  = 1'b1;
            pcsrc  = zero;
            w_next = S_IDLE;
          end
          C_J: begin
            pc_en  = 1'b1;
            jump   = 1'b1;
            w_next = S_IDLE;
          end
          C_LW, C_SW:       w_next = S_MEM;
          C_RTYPE, C_ADDI:  w_next = S_WB;
          default: begin
            pc_en  = 1'b1;
            w_next = S_IDLE;
          end
        endcase
      end
      S_MEM: begin
        alusrc     = 1'b1;
        alucontrol = ALU_ADD;
        if (dmem_ready) begin
          dmem_en = 1'b1;
          dmem_we = (r_class == C_SW);
          if (r_class == C_SW) begin
            pc_en  = 1'b1;
            w_next = S_IDLE;
          end else begin
            w_next = S_WB;
          end
        end else if (w_timeout) begin
          // abort drops the request so no late write can land
          exc    = 1'b1;
          pc_en  = 1'b1;
          w_next = S_IDLE;
        end else begin
          dmem_en = 1'b1;
          dmem_we = (r_class == C_SW);
        end
      end
      S_WB: begin
        pc_en    = 1'b1;
        regdst   = (r_class == C_RTYPE);
        memtoreg = (r_class == C_LW);
        if ((r_class == C_RTYPE) || (r_class == C_ADDI)) begin
          alusrc     = (r_class == C_ADDI);
          alucontrol = w_alu_exec;
        end
        if (w_ovf_op && overflow) exc = 1'b1;
        else                      regwrite = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_class <= C_ILLEGAL;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_class <= w_class;
      r_wait <= ((r_state == S_MEM) && (w_next == S_MEM)) ? r_wait + CW'(1) : '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// ============================================================================
// Module   : tb_mc_controller
// Purpose  : Scoreboard bench for mc_controller; per-cycle expected outputs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mc_controller;

  logic        clk;
  logic        rst;
  logic        run;
  logic [31:0] instr;
  logic        zero;
  logic        overflow;
  logic        dmem_ready;
  logic        imem_en, ir_en, pc_en, memtoreg, pcsrc, alusrc, regdst, regwrite, jump;
  logic [2:0]  alucontrol;
  logic        dmem_en, dmem_we, exc, busy;

  mc_controller #(.DMEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr), .zero(zero),
    .overflow(overflow), .dmem_ready(dmem_ready),
    .imem_en(imem_en), .ir_en(ir_en), .pc_en(pc_en), .memtoreg(memtoreg),
    .pcsrc(pcsrc), .alusrc(alusrc), .regdst(regdst), .regwrite(regwrite),
    .jump(jump), .alucontrol(alucontrol), .dmem_en(dmem_en), .dmem_we(dmem_we),
    .exc(exc), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [15:0] B_IMEM   = 16'h8000;
  localparam logic [15:0] B_IR     = 16'h4000;
  localparam logic [15:0] B_PC     = 16'h2000;
  localparam logic [15:0] B_M2R    = 16'h1000;
  localparam logic [15:0] B_PCSRC  = 16'h0800;
  localparam logic [15:0] B_ALUSRC = 16'h0400;
  localparam logic [15:0] B_REGDST = 16'h0200;
  localparam logic [15:0] B_REGW   = 16'h0100;
  localparam logic [15:0] B_JUMP   = 16'h0080;
  localparam logic [15:0] A_ADD    = 16'h0020;
  localparam logic [15:0] A_SUB    = 16'h0060;
  localparam logic [15:0] A_OR     = 16'h0010;
  localparam logic [15:0] A_SLT    = 16'h0070;
  localparam logic [15:0] B_DEN    = 16'h0008;
  localparam logic [15:0] B_DWE    = 16'h0004;
  localparam logic [15:0] B_EXC    = 16'h0002;
  localparam logic [15:0] B_BUSY   = 16'h0001;

  wire [15:0] w_obs = {imem_en, ir_en, pc_en, memtoreg, pcsrc, alusrc, regdst,
                       regwrite, jump, alucontrol, dmem_en, dmem_we, exc, busy};

  logic [15:0] sb_q[$];
  logic [15:0] exp_v;
  int          n_cmp = 0;
  int          n_err = 0;

  // IDLE with run=1, then FETCH, FWAIT, DECODE (legal instruction)
  task automatic push_front_end();
    sb_q.push_back(16'h0000);
    sb_q.push_back(B_IMEM | B_BUSY);
    sb_q.push_back(B_IR | B_BUSY);
    sb_q.push_back(B_BUSY);
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (w_obs !== 16'h0000) begin
        n_err++;
        $display("FAIL reset cyc%0d: got %h expected %h", i, w_obs, 16'h0000);
      end
    end
    @(negedge clk);
    rst = 1'b0; run = 1'b0;
  endtask

  task automatic test_add();
    instr = 32'h01095020; overflow = 1'b0; zero = 1'b0; dmem_ready = 1'b0;
    push_front_end();
    sb_q.push_back(A_ADD | B_BUSY);
    sb_q.push_back(B_PC | B_REGDST | B_REGW | A_ADD | B_BUSY);
    sb_q.push_back(16'h0000);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      run = (i == 0);
      #1;
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (w_obs !== exp_v) begin
        n_err++;
        $display("FAIL add cyc%0d: got %h expected %h", i, w_obs, exp_v);
      end
    end
  endtask

  task automatic test_beq_j();
    logic [31:0] t_instr[3] = '{32'h11090003, 32'h11090003, 32'h08000010};
    logic        t_zero[3]  = '{1'b1, 1'b0, 1'b1};
    logic [15:0] t_exec[3]  = '{B_PC | B_PCSRC | A_SUB | B_BUSY,
                                B_PC | A_SUB | B_BUSY,
                                B_PC | B_JUMP | B_BUSY};
    for (int k = 0; k < 3; k++) begin
      instr = t_instr[k]; zero = t_zero[k];
      push_front_end();
      sb_q.push_back(t_exec[k]);
      sb_q.push_back(16'h0000);
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        run = (i == 0);
        #1;
        exp_v = sb_q.pop_front();
        n_cmp++;
        if (w_obs !== exp_v) begin
          n_err++;
          $display("FAIL branch%0d cyc%0d: got %h expected %h", k, i, w_obs, exp_v);
        end
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_lw_wait();
    instr = 32'h8D090004;
    push_front_end();
    sb_q.push_back(B_ALUSRC | A_ADD | B_BUSY);
    for (int m = 0; m < 3; m++) sb_q.push_back(B_DEN | B_ALUSRC | A_ADD | B_BUSY);
    sb_q.push_back(B_PC | B_M2R | B_REGW | B_BUSY);
    sb_q.push_back(16'h0000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      run = (i == 0);
      dmem_ready = (i == 2) || (i == 7);  // ready in FWAIT must be ignored
      #1;
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (w_obs !== exp_v) begin
        n_err++;
        $display("FAIL lw_wait cyc%0d: got %h expected %h", i, w_obs, exp_v);
      end
    end
    dmem_ready = 1'b0;
  endtask

  task automatic test_sw_timeout();
    instr = 32'hAD090004; dmem_ready = 1'b0;
    push_front_end();
    sb_q.push_back(B_ALUSRC | A_ADD | B_BUSY);
    for (int m = 0; m < 15; m++) sb_q.push_back(B_DEN | B_DWE | B_ALUSRC | A_ADD | B_BUSY);
    sb_q.push_back(B_PC | B_EXC | B_ALUSRC | A_ADD | B_BUSY);
    sb_q.push_back(16'h0000);
    sb_q.push_back(16'h0000);
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      run = (i == 0);
      #1;
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (w_obs !== exp_v) begin
        n_err++;
        $display("FAIL sw_timeout cyc%0d: got %h expected %h", i, w_obs, exp_v);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] t_instr[2] = '{32'hFC000000, 32'h01095021};
    for (int k = 0; k < 2; k++) begin
      instr = t_instr[k];
      sb_q.push_back(16'h0000);
      sb_q.push_back(B_IMEM | B_BUSY);
      sb_q.push_back(B_IR | B_BUSY);
      sb_q.push_back(B_PC | B_EXC | B_BUSY);
      sb_q.push_back(16'h0000);
      sb_q.push_back(16'h0000);
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        run = (i == 0);
        #1;
        exp_v = sb_q.pop_front();
        n_cmp++;
        if (w_obs !== exp_v) begin
          n_err++;
          $display("FAIL illegal%0d cyc%0d: got %h expected %h", k, i, w_obs, exp_v);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] t_instr[3] = '{32'h21080001, 32'h01095022, 32'h0109502A};
    logic [15:0] t_exec[3]  = '{B_ALUSRC | A_ADD | B_BUSY, A_SUB | B_BUSY, A_SLT | B_BUSY};
    logic [15:0] t_wb[3]    = '{B_PC | B_ALUSRC | A_ADD | B_EXC | B_BUSY,
                                B_PC | B_REGDST | A_SUB | B_EXC | B_BUSY,
                                B_PC | B_REGDST | B_REGW | A_SLT | B_BUSY};
    overflow = 1'b1;
    for (int k = 0; k < 3; k++) begin
      instr = t_instr[k];
      push_front_end();
      sb_q.push_back(t_exec[k]);
      sb_q.push_back(t_wb[k]);
      sb_q.push_back(16'h0000);
      for (int i = 0; i < 7; i++) begin
        @(negedge clk);
        run = (i == 0);
        #1;
        exp_v = sb_q.pop_front();
        n_cmp++;
        if (w_obs !== exp_v) begin
          n_err++;
          $display("FAIL overflow%0d cyc%0d: got %h expected %h", k, i, w_obs, exp_v);
        end
      end
    end
    overflow = 1'b0;
  endtask

  task automatic test_back_to_back();
    instr = 32'hAD090004;
    push_front_end();
    sb_q.push_back(B_ALUSRC | A_ADD | B_BUSY);
    sb_q.push_back(B_DEN | B_DWE | B_PC | B_ALUSRC | A_ADD | B_BUSY);
    push_front_end();
    sb_q.push_back(A_OR | B_BUSY);
    sb_q.push_back(B_PC | B_REGDST | B_REGW | A_OR | B_BUSY);
    sb_q.push_back(16'h0000);
    sb_q.push_back(16'h0000);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      run = (i < 12);
      dmem_ready = 1'b1;
      if (i == 6) instr = 32'h01095025;
      #1;
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (w_obs !== exp_v) begin
        n_err++;
        $display("FAIL back_to_back cyc%0d: got %h expected %h", i, w_obs, exp_v);
      end
    end
    dmem_ready = 1'b0;
  endtask

  task automatic test_reset_in_mem();
    instr = 32'h8D090004;
    push_front_end();
    sb_q.push_back(B_ALUSRC | A_ADD | B_BUSY);
    sb_q.push_back(B_DEN | B_ALUSRC | A_ADD | B_BUSY);
    sb_q.push_back(16'h0000);
    sb_q.push_back(16'h0000);
    push_front_end();
    sb_q.push_back(B_ALUSRC | A_ADD | B_BUSY);
    sb_q.push_back(B_DEN | B_ALUSRC | A_ADD | B_BUSY);
    sb_q.push_back(B_PC | B_M2R | B_REGW | B_BUSY);
    sb_q.push_back(16'h0000);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      run = (i == 0) || (i == 6) || (i == 8);
      rst = (i == 6) || (i == 7);
      dmem_ready = (i == 13);
      #1;
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (w_obs !== exp_v) begin
        n_err++;
        $display("FAIL reset_in_mem cyc%0d: got %h expected %h", i, w_obs, exp_v);
      end
    end
    run = 1'b0; rst = 1'b0; dmem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; instr = 32'h0; zero = 1'b0;
    overflow = 1'b0; dmem_ready = 1'b0;
    #1;
    test_reset();
    test_add();
    test_beq_j();
    test_lw_wait();
    test_sw_timeout();
    test_illegal();
    test_overflow();
    test_back_to_back();
    test_reset_in_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
